// File: rtl/cmd_dispatch_pkg.sv
// Shared command header: opcode encodings, widths and slot record used by cmd_dispatch.
package cmd_dispatch_pkg;

  localparam int unsigned CMD_W   = 3;
  localparam int unsigned ARG_W   = 32;
  localparam int unsigned ENTRY_W = CMD_W + ARG_W;
  localparam int unsigned DROP_W  = 16;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP     = 3'd0,
    CMD_STEP    = 3'd1,
    CMD_LOAD    = 3'd2,
    CMD_ADVANCE = 3'd3,
    CMD_PAUSE   = 3'd4,
    CMD_RUN     = 3'd5,
    CMD_CLEAR   = 3'd6,
    CMD_RESET   = 3'd7
  } cmd_op_e;

  typedef struct packed {
    logic             full;
    logic [CMD_W-1:0] cmd;
    logic [ARG_W-1:0] arg0;
  } slot_t;

  function automatic logic [ARG_W-1:0] sat_add_arg(input logic [ARG_W-1:0] a,
                                                   input logic [ARG_W-1:0] b);
    logic [ARG_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ARG_W] ? '1 : s[ARG_W-1:0];
  endfunction

  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a,
                                                     input logic [1:0]        n);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {{(DROP_W-1){1'b0}}, n};
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead FIFO with wrap-around pointers; head reads as zero while empty.
module cmd_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 35,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Two-source command dispatcher: per-source holding slots feeding a show-ahead FIFO.
// Optional CMD_DISPATCH_COALESCE_EN merges back-to-back CMD_ADVANCE strobes in slot B.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  a_cmd,
  input  logic [ARG_W-1:0]  a_arg0,
  input  logic              a_valid,
  input  logic [CMD_W-1:0]  b_cmd,
  input  logic [ARG_W-1:0]  b_arg0,
  input  logic              b_valid,
  output logic [CMD_W-1:0]  out_cmd,
  output logic [ARG_W-1:0]  out_arg0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  slot_t               slot_a_q, slot_a_d;
  slot_t               slot_b_q, slot_b_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [1:0]          drops;
  logic                xfer_a, xfer_b;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [ENTRY_W-1:0]  push_data, head;

  // Source A has priority; at most one slot moves into the FIFO per cycle.
  assign xfer_a    = !fifo_full && slot_a_q.full;
  assign xfer_b    = !fifo_full && !slot_a_q.full && slot_b_q.full;
  assign push_data = xfer_a ? {slot_a_q.cmd, slot_a_q.arg0}
                            : {slot_b_q.cmd, slot_b_q.arg0};

  always_comb begin
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    drops    = 2'd0;
    if (xfer_a) slot_a_d.full = 1'b0;
    if (xfer_b) slot_b_d.full = 1'b0;

    if (a_valid) begin
      if (!slot_a_d.full) slot_a_d = '{full: 1'b1, cmd: a_cmd, arg0: a_arg0};
      else                drops    = drops + 2'd1;
    end

    if (b_valid) begin
      if (!slot_b_d.full) begin
        slot_b_d = '{full: 1'b1, cmd: b_cmd, arg0: b_arg0};
      end else begin
`ifdef CMD_DISPATCH_COALESCE_EN
        if (b_cmd == CMD_ADVANCE && slot_b_q.cmd == CMD_ADVANCE)
          slot_b_d.arg0 = sat_add_arg(slot_b_q.arg0, b_arg0);
        else
          drops = drops + 2'd1;
`else
        drops = drops + 2'd1;
`endif
      end
    end

    drop_d = sat_add_drop(drop_q, drops);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_a_q <= '0;
      slot_b_q <= '0;
      drop_q   <= '0;
    end else begin
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
      drop_q   <= drop_d;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (xfer_a || xfer_b),
    .push_data_i (push_data),
    .pop_i       (out_ready),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign out_cmd    = head[ENTRY_W-1:ARG_W];
  assign out_arg0   = head[ARG_W-1:0];
  assign drop_count = drop_q;
  assign busy       = slot_a_q.full || slot_b_q.full || (fifo_count != '0);

endmodule
